// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends len bits of a latched pattern MSB-first,
// repeated reps times (0 = until stop) with an optional idle gap between repetitions.
module seq_pattern_tx #(
  parameter int MAX_LEN = 8,
  parameter int REP_W   = 4,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  input  logic [3:0]         gap,
  input  logic               stop,
  output logic               x,
  output logic               x_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } state_e;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0] REP_ZERO = REP_W'(0);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [3:0]         gap_q, gap_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Selects bit idx of vec; a shift keeps the index width independent of MAX_LEN.
  function automatic logic pick_bit(input logic [MAX_LEN-1:0] vec, input logic [LEN_W-1:0] idx);
    logic [MAX_LEN-1:0] sh;
    sh = vec >> idx;
    return sh[0];
  endfunction

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    reps_d    = reps_q;
    rep_cnt_d = rep_cnt_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if ((len == LEN_ZERO) || (len > LEN_MAX)) begin
            err_d = 1'b1;
          end else begin
            state_d   = SEND;
            pat_d     = pattern;
            len_d     = len;
            reps_d    = reps;
            gap_d     = gap;
            idx_d     = len - LEN_ONE;
            rep_cnt_d = REP_ZERO;
            gap_cnt_d = 4'd0;
            x_d       = pick_bit(pattern, len - LEN_ONE);
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (stop) begin
          state_d = IDLE;
        end else if (idx_q != LEN_ZERO) begin
          idx_d     = idx_q - LEN_ONE;
          x_d       = pick_bit(pat_q, idx_q - LEN_ONE);
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else if ((reps_q != REP_ZERO) && (rep_cnt_q == reps_q - REP_ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          // rep_cnt only matters for a finite count, so wrapping in continuous mode is harmless
          rep_cnt_d = rep_cnt_q + REP_ONE;
          busy_d    = 1'b1;
          if (gap_q != 4'd0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q - 4'd1;
          end else begin
            idx_d     = len_q - LEN_ONE;
            x_d       = pick_bit(pat_q, len_q - LEN_ONE);
            x_valid_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (gap_cnt_q == 4'd0) begin
          state_d   = SEND;
          idx_d     = len_q - LEN_ONE;
          x_d       = pick_bit(pat_q, len_q - LEN_ONE);
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
          busy_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pat_q     <= {MAX_LEN{1'b0}};
      len_q     <= LEN_ZERO;
      idx_q     <= LEN_ZERO;
      reps_q    <= REP_ZERO;
      rep_cnt_q <= REP_ZERO;
      gap_q     <= 4'd0;
      gap_cnt_q <= 4'd0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      reps_q    <= reps_d;
      rep_cnt_q <= rep_cnt_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: the driver pushes the expected per-cycle
// output trace of each transaction, the monitor pops and compares every cycle.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'd0;
  logic [3:0] len = 4'd0;
  logic [3:0] reps = 4'd0;
  logic [3:0] gap = 4'd0;
  logic       stop = 1'b0;
  logic       x, x_valid, busy, done, err;

  // expected tuple {x, x_valid, busy, done, err}; empty queue means all-zero idle
  logic [4:0] q[$];
  int errors = 0;
  int checks = 0;
  logic       det_en = 1'b0;
  int         det_req = 0;
  int         det_seen = 0;
  int         fires = 0;
  logic [2:0] hist = 3'b000;
  logic       end_req = 1'b0;
  logic       end_seen = 1'b0;

  seq_pattern_tx #(.MAX_LEN(8), .REP_W(4), .LEN_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .gap(gap), .stop(stop), .x(x), .x_valid(x_valid), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: element i of the output trace following an accepted start.
  function automatic logic [4:0] exp_el(input logic [7:0] p, input int l, input int r, input int g, input int i);
    int total, o;
    logic [7:0] sh;
    total = r * l + (r - 1) * g;
    if (r != 0 && i == total) return 5'b00010;
    if (r != 0 && i > total) return 5'b00000;
    o = i % (l + g);
    if (o < l) begin
      sh = p >> (l - 1 - o);
      return {sh[0], 4'b1100};
    end
    return 5'b00100;
  endfunction

  // Issue one start; returns in the done cycle, the err cycle, or the cycle after the stop edge.
  task automatic start_txn(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                           input logic [3:0] g, input int k, input bit poke);
    int n, li, ri, gi;
    li = int'(l); ri = int'(r); gi = int'(g);
    pattern = p; len = l; reps = r; gap = g; start = 1'b1; stop = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    pattern = 8'($urandom); len = 4'($urandom); reps = 4'($urandom); gap = 4'($urandom);
    if (li == 0 || li > 8) begin
      q.push_back(5'b00001);
      return;
    end
    n = (k > 0) ? k : ri * li + (ri - 1) * gi + 1;
    for (int i = 0; i < n; i++) q.push_back(exp_el(p, li, ri, gi, i));
    for (int j = 1; j <= n - 1; j++) begin
      @(posedge clk); #1;
      start = (poke && j == 1 && n >= 3);
      pattern = 8'($urandom); len = 4'($urandom_range(1, 8));
      reps = 4'($urandom); gap = 4'($urandom);
    end
    start = 1'b0;
    if (k > 0) begin
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
    end
  endtask

  task automatic det_run(input logic [3:0] g);
    det_en = 1'b1;
    start_txn(8'b0000_0101, 4'd3, 4'd2, g, 0, 1'b0);
    @(posedge clk); #1;
    det_req = det_req + 1;
    @(posedge clk); #1;
    det_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: owns all counters; compares DUT outputs to the scoreboard each cycle.
  always @(negedge clk) begin
    logic [4:0] act, expv;
    act  = {x, x_valid, busy, done, err};
    expv = (q.size() > 0) ? q.pop_front() : 5'b00000;
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL out_trace t=%0t actual {x,xv,busy,done,err}=%b required=%b", $time, act, expv);
    end
    if (!det_en) begin
      fires = 0;
      hist  = 3'b000;
    end else if (x_valid) begin
      hist = {hist[1:0], x};
      if (hist == 3'b101) fires = fires + 1;
    end
    if (det_req != det_seen) begin
      det_seen = det_req;
      checks = checks + 1;
      if (fires != 2) begin
        errors = errors + 1;
        $display("FAIL det101 actual=%0d required=2", fires);
      end
    end
    if (end_req && !end_seen) begin
      end_seen = 1'b1;
      checks = checks + 1;
      if (q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL trace_drained actual=%0d required=0", q.size());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p;
    logic [3:0] l, r, g;
    int n, k;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    det_run(4'd0);
    det_run(4'd2);

    start_txn(8'h5A, 4'd0, 4'd1, 4'd0, 0, 1'b0);
    start_txn(8'h5A, 4'd9, 4'd1, 4'd0, 0, 1'b0);
    idle(2);
    start_txn(8'hC3, 4'd5, 4'd2, 4'd1, 0, 1'b1);
    idle(1);

    // start together with stop in idle must do nothing
    pattern = 8'hFF; len = 4'd3; reps = 4'd1; start = 1'b1; stop = 1'b1;
    idle(1);
    start = 1'b0; stop = 1'b0;
    idle(2);

    start_txn(8'b0000_0010, 4'd2, 4'd0, 4'd0, 7, 1'b0);
    idle(2);

    start_txn(8'h96, 4'd3, 4'd1, 4'd0, 0, 1'b0);
    start_txn(8'hFF, 4'd8, 4'd2, 4'd0, 0, 1'b0);
    idle(2);

    start_txn(8'h2D, 4'd2, 4'd15, 4'd1, 0, 1'b0);
    idle(1);

    // asynchronous reset in the third cycle of an 8-bit send
    pattern = 8'hB7; len = 4'd8; reps = 4'd1; gap = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) q.push_back(exp_el(8'hB7, 8, 1, 0, i));
    idle(2);
    #1;
    reset_n = 1'b0;
    q.delete();
    idle(3);
    reset_n = 1'b1;
    idle(4);

    for (int t = 0; t < 40; t++) begin
      p = 8'($urandom);
      if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      else l = 4'($urandom_range(1, 8));
      r = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      g = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 2));
      k = 0;
      if (r == 4'd0) begin
        k = $urandom_range(1, 40);
      end else if ($urandom_range(0, 3) == 0) begin
        n = int'(r) * int'(l) + (int'(r) - 1) * int'(g) + 1;
        if (n >= 2) k = $urandom_range(1, n - 1);
      end
      start_txn(p, l, r, g, k, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(4);
    end_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
